// File: rtl/add_pkg.sv
// Shared definitions for the adder result path: default width, accumulator FSM
// encoding and the width derivations used by add_result_accumulator.
package add_pkg;

  localparam int ADD_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } acc_state_e;

  // Beat counter must hold the value BURST_LEN itself, not just BURST_LEN-1.
  function automatic int cnt_w(input int burst_len);
    return $clog2(burst_len + 1);
  endfunction

  function automatic int sum_w(input int width, input int burst_len);
    return width + cnt_w(burst_len);
  endfunction

endpackage

// File: rtl/add_result_accumulator.sv
// Sums bursts of adder results and presents each burst total on a valid/ready
// output, stalling the input stream while the total waits to be taken.
module add_result_accumulator
  import add_pkg::*;
#(
  parameter int WIDTH     = ADD_WIDTH,
  parameter int BURST_LEN = 4,
  parameter int CNT_W     = cnt_w(BURST_LEN),
  parameter int SUM_W     = sum_w(WIDTH, BURST_LEN)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SUM_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_count
);

  acc_state_e       state_q, state_d;
  logic [SUM_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic             accept;

  assign in_ready  = (state_q != ST_HOLD);
  assign accept    = in_valid && in_ready;
  assign cnt_inc   = cnt_q + CNT_W'(1);
  assign out_valid = (state_q == ST_HOLD);
  assign out_sum   = acc_q;
  assign out_count = cnt_q;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          acc_d   = SUM_W'(in_data);
          cnt_d   = CNT_W'(1);
          state_d = (in_last || BURST_LEN == 1) ? ST_HOLD : ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        // Idle cycles inside a burst simply hold acc and cnt.
        if (accept) begin
          acc_d = acc_q + SUM_W'(in_data);
          cnt_d = cnt_inc;
          if (in_last || cnt_inc == CNT_W'(BURST_LEN)) state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_add_result_accumulator.sv
// Directed bench for add_result_accumulator (WIDTH=8, BURST_LEN=4).
module tb_add_result_accumulator;

  localparam int WIDTH     = 8;
  localparam int BURST_LEN = 4;
  localparam int CNT_W     = 3;
  localparam int SUM_W     = 11;

  logic             clock = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [SUM_W-1:0] out_sum;
  logic [CNT_W-1:0] out_count;

  int n_cmp = 0;
  int n_bad = 0;

  add_result_accumulator #(.WIDTH(WIDTH), .BURST_LEN(BURST_LEN)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_count (out_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Present one beat for one cycle; the DUT must be ready for it.
  task automatic send(input logic [WIDTH-1:0] d, input logic last);
    chk("in_ready_before_beat", 32'(in_ready), 1);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
  endtask

  task automatic expect_total(input string tag, input int sum, input int cnt);
    chk({tag, "_valid"}, 32'(out_valid), 1);
    chk({tag, "_sum"},   32'(out_sum),   32'(sum));
    chk({tag, "_count"}, 32'(out_count), 32'(cnt));
    chk({tag, "_ready"}, 32'(in_ready),  0);
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;

    // 1. reset state, then basic burst
    tick(); tick();
    reset = 1'b0;
    chk("rst_in_ready",  32'(in_ready),  1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_sum",   32'(out_sum),   0);
    chk("rst_out_count", 32'(out_count), 0);
    send(8'd1, 1'b0); send(8'd2, 1'b0); send(8'd3, 1'b0);
    chk("basic_not_yet_valid", 32'(out_valid), 0);
    send(8'd4, 1'b0);
    expect_total("basic", 10, 4);
    tick();
    chk("basic_one_cycle", 32'(out_valid), 0);

    // 2. full-scale values
    for (int i = 0; i < 4; i++) send(8'd255, 1'b0);
    expect_total("fullscale", 1020, 4);
    tick();

    // 3. early in_last and one-beat burst
    send(8'd5, 1'b0); send(8'd7, 1'b1);
    expect_total("short2", 12, 2);
    tick();
    chk("short2_drop", 32'(out_valid), 0);
    send(8'd9, 1'b1);
    expect_total("short1", 9, 1);
    tick();

    // 4. backpressure
    out_ready = 1'b0;
    send(8'd1, 1'b0); send(8'd2, 1'b0); send(8'd3, 1'b0); send(8'd4, 1'b0);
    in_valid = 1'b1;
    in_data  = 8'd50;
    for (int i = 0; i < 3; i++) begin
      expect_total("bp_hold", 10, 4);
      tick();
    end
    expect_total("bp_hold_end", 10, 4);
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    tick();
    chk("bp_release_valid", 32'(out_valid), 0);
    for (int i = 0; i < 4; i++) send(8'd1, 1'b0);
    expect_total("bp_next", 4, 4);
    tick();

    // 5. reset mid-burst
    send(8'd6, 1'b0); send(8'd6, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_in_ready",  32'(in_ready),  1);
    chk("midrst_out_valid", 32'(out_valid), 0);
    chk("midrst_out_count", 32'(out_count), 0);
    chk("midrst_out_sum",   32'(out_sum),   0);
    for (int i = 0; i < 4; i++) send(8'd9, 1'b0);
    expect_total("midrst_next", 36, 4);
    tick();

    // 6. gapped input
    send(8'd1, 1'b0); send(8'd2, 1'b0);
    for (int i = 0; i < 2; i++) begin
      chk("gap_a_valid", 32'(out_valid), 0);
      tick();
    end
    send(8'd3, 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk("gap_b_valid", 32'(out_valid), 0);
      chk("gap_b_ready", 32'(in_ready),  1);
      tick();
    end
    send(8'd4, 1'b0);
    expect_total("gapped", 10, 4);
    tick();
    chk("gapped_one_cycle", 32'(out_valid), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
